// File: rtl/psum_adder_pack.sv
// Collects one psum per lane, adds the triplet with saturation and emits a
// NoC packet to the output memory; pulses done after every NUM_OUT packets.

module psum_lane #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              valid_i,
  input  logic              clr_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [DWIDTH-1:0] data_o
);
  logic              full_q, full_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              xfer;

  assign ready_o = !full_q;
  assign xfer    = valid_i && !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  // clr only fires when every lane is full, so it never collides with xfer
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (xfer) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
endmodule

module psum_adder_pack #(
  parameter int          DWIDTH   = 8,
  parameter int          PWIDTH   = 47,
  parameter logic [2:0]  SRC_ADDR = 3'b100,
  parameter logic [3:0]  DST_ADDR = 4'b0101,
  parameter int          NUM_OUT  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] in0_data,
  input  logic [DWIDTH-1:0] in1_data,
  input  logic [DWIDTH-1:0] in2_data,
  input  logic              in0_valid,
  input  logic              in1_valid,
  input  logic              in2_valid,
  output logic              in0_ready,
  output logic              in1_ready,
  output logic              in2_ready,
  output logic [PWIDTH-1:0] out_packet,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);
  localparam int         NUM_LANES = 3;
  localparam logic       COLLECT   = 1'b0;
  localparam logic       SEND      = 1'b1;
  localparam logic [7:0] LAST_CNT  = 8'(NUM_OUT - 1);
  localparam logic [DWIDTH+1:0] MAX_SUM = {2'b00, {DWIDTH{1'b1}}};

  logic [NUM_LANES-1:0][DWIDTH-1:0] ln_in, ln_held;
  logic [NUM_LANES-1:0]             ln_valid, ln_ready, ln_full;
  logic                             load, out_acc;

  assign ln_in    = {in2_data, in1_data, in0_data};
  assign ln_valid = {in2_valid, in1_valid, in0_valid};
  assign {in2_ready, in1_ready, in0_ready} = ln_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      psum_lane #(.DWIDTH(DWIDTH)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (ln_in[g]),
        .valid_i (ln_valid[g]),
        .clr_i   (load),
        .ready_o (ln_ready[g]),
        .full_o  (ln_full[g]),
        .data_o  (ln_held[g])
      );
    end
  endgenerate

  logic              state_q, state_d;
  logic [PWIDTH-1:0] pkt_q, pkt_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DWIDTH+1:0] sum;
  logic [DWIDTH-1:0] res;

  assign load    = (state_q == COLLECT) && (&ln_full);
  assign out_acc = (state_q == SEND) && out_ready;

  // Two guard bits hold the worst case 3*(2^DWIDTH-1) without wrapping
  assign sum = {2'b00, ln_held[0]} + {2'b00, ln_held[1]} + {2'b00, ln_held[2]};
  assign res = (sum > MAX_SUM) ? {DWIDTH{1'b1}} : sum[DWIDTH-1:0];

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      state_d                 = SEND;
      pkt_d                   = '0;
      pkt_d[PWIDTH-1 -: 4]    = DST_ADDR;
      pkt_d[PWIDTH-5 -: 3]    = SRC_ADDR;
      pkt_d[DWIDTH-1:0]       = res;
    end
    if (out_acc) begin
      state_d = COLLECT;
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      pkt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = (state_q == SEND);
  assign out_packet = pkt_q;
  assign done       = done_q;
endmodule

// File: tb/tb_psum_adder_pack.sv
// Directed checks for psum_adder_pack: reset, sum/packet format, lane order,
// saturation, backpressure, row done pulse and mid-operation reset.

module tb_psum_adder_pack;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in0_data = '0, in1_data = '0, in2_data = '0;
  logic        in0_valid = 1'b0, in1_valid = 1'b0, in2_valid = 1'b0;
  logic        in0_ready, in1_ready, in2_ready;
  logic [46:0] out_packet;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

  psum_adder_pack #(.DWIDTH(8), .PWIDTH(47), .SRC_ADDR(3'b100), .DST_ADDR(4'b0101), .NUM_OUT(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in1_data(in1_data), .in2_data(in2_data),
    .in0_valid(in0_valid), .in1_valid(in1_valid), .in2_valid(in2_valid),
    .in0_ready(in0_ready), .in1_ready(in1_ready), .in2_ready(in2_ready),
    .out_packet(out_packet), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [46:0] pkt(input logic [7:0] v);
    return {4'b0101, 3'b100, 32'd0, v};
  endfunction

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in0_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    in0_data = a; in1_data = b; in2_data = c;
    in0_valid = 1'b1; in1_valid = 1'b1; in2_valid = 1'b1;
  endtask

  task automatic drop_all();
    in0_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_packet !== 47'd0) begin n_fail++; $display("FAIL reset_out_packet got=%h exp=0", out_packet); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if ({in2_ready, in1_ready, in0_ready} !== 3'b111) begin n_fail++; $display("FAIL reset_ready got=%b exp=111", {in2_ready, in1_ready, in0_ready}); end
    tick();
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    set_all(8'd3, 8'd4, 8'd5);
    tick();
    drop_all();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    n_cmp++; if ({in2_ready, in1_ready, in0_ready} !== 3'b000) begin n_fail++; $display("FAIL basic_full got=%b exp=000", {in2_ready, in1_ready, in0_ready}); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_packet !== pkt(8'd12)) begin n_fail++; $display("FAIL basic_packet got=%h exp=%h", out_packet, pkt(8'd12)); end
    n_cmp++; if ({in2_ready, in1_ready, in0_ready} !== 3'b111) begin n_fail++; $display("FAIL basic_cleared got=%b exp=111", {in2_ready, in1_ready, in0_ready}); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accepted got=%b exp=0", out_valid); end
  endtask

  task automatic test_order();
    do_reset();
    out_ready = 1'b1;
    in2_data = 8'd10; in2_valid = 1'b1;
    tick();
    in2_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || in2_ready !== 1'b0) begin n_fail++; $display("FAIL order_wait1 valid=%b in2_ready=%b exp 0/0", out_valid, in2_ready); end
      tick();
    end
    in0_data = 8'd20; in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || in2_ready !== 1'b0 || in0_ready !== 1'b0) begin n_fail++; $display("FAIL order_wait2 valid=%b in2_ready=%b in0_ready=%b exp 0/0/0", out_valid, in2_ready, in0_ready); end
      tick();
    end
    in1_data = 8'd30; in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in2_ready !== 1'b0) begin n_fail++; $display("FAIL order_latency valid=%b in2_ready=%b exp 0/0", out_valid, in2_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_packet !== pkt(8'd60)) begin n_fail++; $display("FAIL order_packet valid=%b got=%h exp=%h", out_valid, out_packet, pkt(8'd60)); end
    n_cmp++; if (in2_ready !== 1'b1) begin n_fail++; $display("FAIL order_release in2_ready=%b exp=1", in2_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [7:0] c [3];
    logic [7:0] e [3];
    a = '{8'd200, 8'd85, 8'd0};
    b = '{8'd100, 8'd85, 8'd0};
    c = '{8'd50,  8'd85, 8'd0};
    e = '{8'd255, 8'd255, 8'd0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_all(a[i], b[i], c[i]);
      tick();
      drop_all();
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_packet !== pkt(e[i])) begin n_fail++; $display("FAIL sat_%0d valid=%b got=%h exp=%h", i, out_valid, out_packet, pkt(e[i])); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    set_all(8'd1, 8'd1, 8'd1);
    tick();
    drop_all();
    tick();
    set_all(8'd1, 8'd1, 8'd1);
    tick();
    drop_all();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_packet !== pkt(8'd3)) begin n_fail++; $display("FAIL bp_hold_%0d valid=%b got=%h exp=%h", i, out_valid, out_packet, pkt(8'd3)); end
      n_cmp++; if ({in2_ready, in1_ready, in0_ready} !== 3'b000) begin n_fail++; $display("FAIL bp_lanes_%0d got=%b exp=000", i, {in2_ready, in1_ready, in0_ready}); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept1 got=%b exp=0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_packet !== pkt(8'd3)) begin n_fail++; $display("FAIL bp_second valid=%b got=%h exp=%h", out_valid, out_packet, pkt(8'd3)); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept2 got=%b exp=0", out_valid); end
  endtask

  task automatic test_row_count();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_all(8'(i), 8'd1, 8'd1);
      tick();
      drop_all();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL row_done_idle_%0d got=%b exp=0", i, done); end
      tick();
      n_cmp++; if (out_packet !== pkt(8'(i + 2)) || done !== 1'b0) begin n_fail++; $display("FAIL row_pkt_%0d got=%h done=%b exp=%h/0", i, out_packet, done, pkt(8'(i + 2))); end
      tick();
      n_cmp++; if (done !== ((i == 4) || (i == 9))) begin n_fail++; $display("FAIL row_done_%0d got=%b exp=%b", i, done, (i == 4) || (i == 9)); end
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL row_done_width got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    in0_data = 8'd9; in1_data = 8'd9;
    in0_valid = 1'b1; in1_valid = 1'b1;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_cmp++; if ({in1_ready, in0_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_filled got=%b exp=00", {in1_ready, in0_ready}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in2_ready, in1_ready, in0_ready} !== 3'b111 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async ready=%b valid=%b exp 111/0", {in2_ready, in1_ready, in0_ready}, out_valid); end
    #1;
    rst_n = 1'b1;
    tick();
    in2_data = 8'd7; in2_valid = 1'b1;
    tick();
    in2_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || {in2_ready, in1_ready, in0_ready} !== 3'b011) begin n_fail++; $display("FAIL rmid_after_%0d valid=%b ready=%b exp 0/011", i, out_valid, {in2_ready, in1_ready, in0_ready}); end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_saturation();
    test_backpressure();
    test_row_count();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_adder_pack.md
# psum_adder_pack

Downstream of the psum adder depacketizer. Collects one partial sum from each of its three lanes:
- lane 0 from the PE0 queue (source 3);
- lane 1 from the PE1 queue (source 1);
- lane 2 from the PE2 queue (source 0).

It adds the three values with saturation and repacketizes the result into a PWIDTH-bit NoC packet for the output memory. It also counts emitted outputs and pulses `done` when a full output row has been sent.

## Interface
- DWIDTH, 8, width of each partial sum and of the result field.
- PWIDTH, 47, packet width.
- SRC_ADDR, 3'b100, value placed in source field [42:40].
- DST_ADDR, 4'b0101, value placed in destination field [46:43].
- NUM_OUT, 5, outputs per row; `done` pulses after the NUM_OUT-th packet is accepted (2 ≤ NUM_OUT ≤ 255).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in0_data / in1_data / in2_data  in  DWIDTH  lane psums.
- in0_valid / in1_valid / in2_valid  in  1  lane data valid.
- in0_ready / in1_ready / in2_ready  out  1  lane can accept.
- out_packet  out  PWIDTH  result packet.
- out_valid  out  1  packet valid.
- out_ready  in  1  downstream accepts.
- done  out  1  one-cycle pulse at end of row.

## Operation
- Handshake on every channel: transfer occurs on a rising edge where valid && ready. Valid, once high, holds with stable data until the transfer. Ready may toggle freely.
- Each lane has a one-entry holding register plus a `full_k` flag.
  - `ink_ready = !full_k`. This is combinational and does not depend on the other lanes.
  - A transfer loads the register and sets `full_k`.
  - Lanes fill independently and in any order. A full lane refuses further data until the triplet is consumed.
- FSM, two states, reset to COLLECT.
  - COLLECT: when full_0 && full_1 && full_2 (sampled at an edge), perform all of the following on that edge:
    - compute the sum;
    - load out_packet;
    - clear all three full flags;
    - go to SEND.
  - SEND: out_valid=1. Lanes may refill during SEND. On out_ready, return to COLLECT. Refilled lanes are kept.
- Arithmetic:
  - sum = in0 + in1 + in2, unsigned, computed at DWIDTH+2 bits.
  - If sum > 2^DWIDTH−1, the result is 2^DWIDTH−1 (saturate). Otherwise the result is the low DWIDTH bits.
- Packet format:
  - [46:43] = DST_ADDR;
  - [42:40] = SRC_ADDR;
  - [39:DWIDTH] = 0;
  - [DWIDTH-1:0] = result.
- Row counter, 8 bits, reset 0:
  - increments on each output transfer;
  - on the transfer that makes it equal NUM_OUT, it wraps to 0 and `done`=1 for the following cycle only.

## Timing
- Reset values while rst_n=0: out_valid=0, out_packet=0, done=0, all full flags=0 (so all inX_ready=1 after reset), counter=0, state COLLECT.
- Reset asserted mid-operation discards held psums and any pending packet immediately (asynchronous). No partial triplet survives.
- Latency: if the last lane transfer happens at edge N, out_valid rises after edge N+1 and out_packet is stable from that point.
- With out_ready held high and all lanes streaming, throughput is one packet per 2 cycles. The cycle sequence is: collect edge, load edge, accept edge (overlaps the next collect).
- out_valid stays high and out_packet stays stable until accepted. There is no timeout.
- Simultaneous events:
  - an output transfer and lane transfers on the same edge are both honoured;
  - if all lanes are full when returning to COLLECT, the next sum loads on the following edge.
- done is registered, one cycle wide, and asserted in the cycle after the NUM_OUT-th acceptance.

## Test plan
- Basic: after reset, send in0=3, in1=4, in2=5 simultaneously with out_ready=1 → one packet with [7:0]=12, [42:40]=3'b100, [46:43]=4'b0101, [39:8]=0; out_valid rises one cycle after the inputs.
- Order independence: send lane 2 (10), wait 5 cycles, lane 0 (20), wait 3 cycles, lane 1 (30) → single packet with value 60; no packet before lane 1 arrives; in2_ready stays 0 until the sum is loaded.
- Saturation: 200+100+50 → result 255; 85+85+85 → 255; 0+0+0 → 0.
- Backpressure: hold out_ready=0 for 10 cycles with a packet pending while lanes present the next triplet (1,1,1) → first packet held stable; lanes fill then deassert ready; after release, the packets 3 and 3 are both delivered in order with nothing lost.
- Row count: stream 5 triplets with NUM_OUT=5 → done pulses exactly once, the cycle after the 5th acceptance; the 6th–10th outputs produce a second pulse.
- Reset mid-operation: fill lanes 0 and 1, then pulse rst_n low → all ready=1, out_valid=0; a subsequent lane 2 input alone produces no packet.
